// File: rtl/cpu_run_pkg.sv
// Shared types for the CPU run-control monitor: run outcome codes, FSM states
// and the stall-counter sizing rule.
package cpu_run_pkg;

  typedef enum logic [1:0] {
    ST_NONE    = 2'd0,
    ST_HALTED  = 2'd1,
    ST_STALL   = 2'd2,
    ST_TIMEOUT = 2'd3
  } run_status_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } run_state_t;

  // A limit of 0 (detection off) or 1 still needs a one-bit counter.
  function automatic int stall_cnt_width(input int limit);
    return (limit <= 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/run_stall_detector.sv
// Per-core stall detector: remembers the last PC seen and counts consecutive
// running cycles on which it did not change; flags the edge the count hits the limit.
module run_stall_detector #(
  parameter int PC_WIDTH    = 64,
  parameter int STALL_LIMIT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                enable,
  input  logic                halted,
  input  logic [PC_WIDTH-1:0] pc,
  output logic                stall
);
  import cpu_run_pkg::*;

  localparam int            CW    = stall_cnt_width(STALL_LIMIT);
  localparam logic [CW-1:0] LIMIT = CW'(STALL_LIMIT);

  logic [PC_WIDTH-1:0] prev_pc_q, prev_pc_d;
  logic [CW-1:0]       cnt_q, cnt_d;

  // NOTE: every variable driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    prev_pc_d = prev_pc_q;
    cnt_d     = cnt_q;
    if (clear) begin
      prev_pc_d = pc;
      cnt_d     = '0;
    end else if (enable) begin
      prev_pc_d = pc;
      if (halted || (pc != prev_pc_q)) begin
        cnt_d = '0;
      end else if (cnt_q != LIMIT) begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // The flag looks at the next count so the run ends on the very edge the limit is reached.
  assign stall = (STALL_LIMIT != 0) && enable && !clear && (cnt_d == LIMIT);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_pc_q <= '0;
      cnt_q     <= '0;
    end else begin
      prev_pc_q <= prev_pc_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: rtl/cpu_run_monitor.sv
// Run-control monitor: after a start pulse counts cycles and ends the run when all
// cores halt, any core's PC stalls, or the cycle budget runs out; reports the outcome.
module cpu_run_monitor #(
  parameter int NUM_CORES   = 1,
  parameter int PC_WIDTH    = 64,
  parameter int MAX_CYCLES  = 200,
  parameter int STALL_LIMIT = 16,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [NUM_CORES-1:0]          halted,
  input  logic [NUM_CORES*PC_WIDTH-1:0] pc,
  output logic                          busy,
  output logic                          done,
  output logic [1:0]                    status,
  output logic [CNT_WIDTH-1:0]          cycle_count,
  output logic [$clog2(NUM_CORES):0]    fault_core,
  output logic [PC_WIDTH-1:0]           fault_pc
);
  import cpu_run_pkg::*;

  localparam int                   FCW   = $clog2(NUM_CORES) + 1;
  localparam logic [CNT_WIDTH-1:0] MAX_C = CNT_WIDTH'(MAX_CYCLES);

  run_state_t           state_q, state_d;
  run_status_t          status_q, status_d, term_status;
  logic [CNT_WIDTH-1:0] count_q, count_d, count_next;
  logic [FCW-1:0]       fcore_q, fcore_d, sel_core;
  logic [PC_WIDTH-1:0]  fpc_q, fpc_d, sel_pc;
  logic                 busy_q, done_q;

  logic                 start_fire, running;
  logic [NUM_CORES-1:0] stall;
  logic [PC_WIDTH-1:0]  pc_arr [NUM_CORES];

  assign running    = (state_q == S_RUN);
  assign start_fire = start && !running;

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
    assign pc_arr[g] = pc[g*PC_WIDTH +: PC_WIDTH];

    run_stall_detector #(
      .PC_WIDTH    (PC_WIDTH),
      .STALL_LIMIT (STALL_LIMIT)
    ) u_stall (
      .clk    (clk),
      .reset  (reset),
      .clear  (start_fire),
      .enable (running),
      .halted (halted[g]),
      .pc     (pc_arr[g]),
      .stall  (stall[g])
    );
  end

  // Saturating increment; the budget check below normally ends the run first.
  assign count_next = (count_q == '1) ? count_q : count_q + CNT_WIDTH'(1);

  always_comb begin
    term_status = ST_NONE;
    if (&halted) begin
      term_status = ST_HALTED;
    end else if (|stall) begin
      term_status = ST_STALL;
    end else if (count_next == MAX_C) begin
      term_status = ST_TIMEOUT;
    end

    // Lowest-index stalling core wins; HALTED and TIMEOUT report core 0.
    sel_core = '0;
    sel_pc   = pc_arr[0];
    if (term_status == ST_STALL) begin
      for (int i = NUM_CORES - 1; i >= 0; i--) begin
        if (stall[i]) begin
          sel_core = FCW'(i);
          sel_pc   = pc_arr[i];
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    count_d  = count_q;
    fcore_d  = fcore_q;
    fpc_d    = fpc_q;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        count_d = count_next;
        if (term_status != ST_NONE) begin
          state_d  = S_DONE;
          status_d = term_status;
          fcore_d  = sel_core;
          fpc_d    = sel_pc;
        end
      end
      S_DONE: begin
        state_d = start ? S_RUN : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (start_fire) begin
      count_d  = '0;
      status_d = ST_NONE;
      fcore_d  = '0;
      fpc_d    = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      status_q <= ST_NONE;
      count_q  <= '0;
      fcore_q  <= '0;
      fpc_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      count_q  <= count_d;
      fcore_q  <= fcore_d;
      fpc_q    <= fpc_d;
      busy_q   <= (state_d == S_RUN);
      done_q   <= (state_d == S_DONE);
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign status      = status_q;
  assign cycle_count = count_q;
  assign fault_core  = fcore_q;
  assign fault_pc    = fpc_q;

endmodule
